// File: rtl/mgia_pkg.sv
// Shared types and constants for the MGIA line-prefetch path.
package mgia_pkg;

    // Fetch engine state
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    localparam int LB_AW       = 7;   // line-buffer address: {bank, 6-bit word index}
    localparam int WORD_W      = 16;  // video RAM / line-buffer word width
    localparam int IDX_W       = 6;   // word index within a line
    localparam int CNT_W       = 7;   // word count, 1..64
    localparam int WPL_DEFAULT = 40;  // 640 px / 16 px per word

endpackage

// File: rtl/mgia_wb_burst_rd.sv
// Wishbone B3 classic sequential-read engine: one outstanding transfer,
// reads count words from base upward and streams each acked word out
// together with its index. A start while busy restarts the burst after
// one idle bus cycle, so a late acknowledge from the old transfer can
// never be taken for the new one.
module mgia_wb_burst_rd import mgia_pkg::*; #(
    parameter int AW = 23
) (
    input  logic                 CLK_I_25MHZ,
    input  logic                 RST_I_N,
    input  logic                 start,
    input  logic                 abort,
    input  logic [AW-1:0]        base,
    input  logic [CNT_W-1:0]     count,
    output logic [AW-1:0]        adr,
    output logic                 cyc,
    output logic                 stb,
    input  logic                 ack,
    input  logic [WORD_W-1:0]    dat,
    output logic                 busy,
    output logic                 last_ack,
    output logic                 dvld,
    output logic [IDX_W-1:0]     didx,
    output logic [WORD_W-1:0]    ddat
);

    fetch_state_e        state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [AW-1:0]       base_q, base_d;
    logic                pend_q, pend_d;
    logic                ack_eff;
    logic                is_last;
    logic                kill;
    logic [CNT_W-1:0]    last_full;

    assign last_full = count - CNT_W'(1);
    assign ack_eff   = ack && (state_q == ST_FETCH);
    assign is_last   = ({1'b0, idx_q} == last_full);
    assign last_ack  = ack_eff && is_last;
    // a restart only kills a burst that has not just taken its final word
    assign kill      = start && (state_q == ST_FETCH) && !last_ack;

    assign busy = (state_q == ST_FETCH);
    assign cyc  = busy;
    assign stb  = busy;
    assign adr  = base_q + AW'(idx_q);
    assign dvld = ack_eff;
    assign didx = idx_q;
    assign ddat = dat;

    // State register; reset drops the bus cycle immediately
    always_ff @(posedge CLK_I_25MHZ or negedge RST_I_N) begin
        if (!RST_I_N) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state: start > abort > pending restart > acknowledge
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        pend_d  = pend_q;
        if (start) begin
            base_d  = base;
            idx_d   = '0;
            state_d = kill ? ST_IDLE : ST_FETCH;
            pend_d  = kill;
        end else if (abort) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
        end else if (pend_q) begin
            state_d = ST_FETCH;
            pend_d  = 1'b0;
        end else if (ack_eff) begin
            if (is_last)
                state_d = ST_IDLE;
            else
                idx_d = idx_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mgia_line_fetch.sv
// MGIA line-prefetch scheduler: fetches the next display line from video
// RAM into the half of the ping-pong line buffer the shifter is not reading.
// Owns bank selection, line addressing and underrun detection; bus
// sequencing lives in mgia_wb_burst_rd.
// Optional: define MGIA_LINE_DOUBLE_EN to show each fetched line twice
// (only every second HSTART_I advances the line).
module mgia_line_fetch import mgia_pkg::*; #(
    parameter int WORDS_PER_LINE = WPL_DEFAULT,
    parameter int AW             = 23
) (
    input  logic                 CLK_I_25MHZ,
    input  logic                 RST_I_N,
    input  logic                 EN_I,
    input  logic [AW-1:0]        BASE_ADR_I,
    input  logic                 VSTART_I,
    input  logic                 HSTART_I,
    output logic [AW-1:0]        ADR_O,
    output logic                 CYC_O,
    output logic                 STB_O,
    input  logic                 ACK_I,
    input  logic [WORD_W-1:0]    DAT_I,
    output logic [LB_AW-1:0]     LB_ADR_O,
    output logic [WORD_W-1:0]    LB_DAT_O,
    output logic                 LB_WE_O,
    output logic                 DISP_BANK_O,
    output logic                 UNDERRUN_O
);

    localparam logic [AW-1:0]    WPL_ADR = AW'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] WPL_CNT = CNT_W'(WORDS_PER_LINE);

    logic [AW-1:0]      line_q;
    logic [AW-1:0]      nxt_line;
    logic [AW-1:0]      fetch_base;
    logic               disp_bank_q;
    logic               fetch_bank_q;
    logic               hst_act;
    logic               evt;
    logic               eng_start;
    logic               eng_abort;
    logic               busy;
    logic               last_ack;
    logic               dvld;
    logic [IDX_W-1:0]   didx;
    logic [WORD_W-1:0]  ddat;
    logic               vld_p1;
    logic [LB_AW-1:0]   lb_adr_p1;
    logic [WORD_W-1:0]  lb_dat_p1;
    logic               underrun_p1;

`ifdef MGIA_LINE_DOUBLE_EN
    logic               par_q;

    // Line parity: only odd HSTARTs (counted from VSTART) advance the line
    always_ff @(posedge CLK_I_25MHZ or negedge RST_I_N) begin
        if (!RST_I_N)
            par_q <= 1'b0;
        else if (VSTART_I)
            par_q <= 1'b0;
        else if (HSTART_I)
            par_q <= ~par_q;
    end

    assign hst_act = HSTART_I && !VSTART_I && par_q;
`else
    assign hst_act = HSTART_I && !VSTART_I;
`endif

    assign evt        = VSTART_I || hst_act;
    assign nxt_line   = line_q + WPL_ADR;
    assign fetch_base = VSTART_I ? BASE_ADR_I : nxt_line;
    // with fetching disabled the event still moves the banks, so any
    // in-flight burst is stopped rather than left writing a displayed bank
    assign eng_start  = evt && EN_I;
    assign eng_abort  = evt && !EN_I;

    // Line address and banking; the write bank is latched at fetch start
    always_ff @(posedge CLK_I_25MHZ or negedge RST_I_N) begin
        if (!RST_I_N) begin
            line_q       <= '0;
            disp_bank_q  <= 1'b0;
            fetch_bank_q <= 1'b0;
        end else if (VSTART_I) begin
            line_q       <= BASE_ADR_I;
            disp_bank_q  <= 1'b1;
            fetch_bank_q <= 1'b0;
        end else if (hst_act) begin
            line_q       <= nxt_line;
            disp_bank_q  <= ~disp_bank_q;
            fetch_bank_q <= disp_bank_q;
        end
    end

    mgia_wb_burst_rd #(.AW(AW)) u_rd (
        .CLK_I_25MHZ (CLK_I_25MHZ),
        .RST_I_N     (RST_I_N),
        .start       (eng_start),
        .abort       (eng_abort),
        .base        (fetch_base),
        .count       (WPL_CNT),
        .adr         (ADR_O),
        .cyc         (CYC_O),
        .stb         (STB_O),
        .ack         (ACK_I),
        .dat         (DAT_I),
        .busy        (busy),
        .last_ack    (last_ack),
        .dvld        (dvld),
        .didx        (didx),
        .ddat        (ddat)
    );

    // Stage p1: line-buffer write one cycle after each accepted ACK
    always_ff @(posedge CLK_I_25MHZ or negedge RST_I_N) begin
        if (!RST_I_N) begin
            vld_p1    <= 1'b0;
            lb_adr_p1 <= '0;
            lb_dat_p1 <= '0;
        end else begin
            vld_p1    <= dvld;
            lb_adr_p1 <= {fetch_bank_q, didx};
            lb_dat_p1 <= ddat;
        end
    end

    // Underrun: a start event found the previous line still incomplete
    always_ff @(posedge CLK_I_25MHZ or negedge RST_I_N) begin
        if (!RST_I_N)
            underrun_p1 <= 1'b0;
        else
            underrun_p1 <= evt && busy && !last_ack;
    end

    assign LB_WE_O     = vld_p1;
    assign LB_ADR_O    = lb_adr_p1;
    assign LB_DAT_O    = lb_dat_p1;
    assign DISP_BANK_O = disp_bank_q;
    assign UNDERRUN_O  = underrun_p1;

endmodule

// File: tb/tb_mgia_line_fetch.sv
// Self-checking bench for mgia_line_fetch: vector table, directed corner
// sequences and randomized frames against a line-level reference model.
module tb_mgia_line_fetch;

    localparam int AW  = 23;
    localparam int WPL = 40;

    logic           clk = 1'b0;
    logic           RST_I_N = 1'b0;
    logic           EN_I = 1'b0;
    logic [AW-1:0]  BASE_ADR_I = '0;
    logic           VSTART_I = 1'b0;
    logic           HSTART_I = 1'b0;
    logic [AW-1:0]  ADR_O;
    logic           CYC_O, STB_O;
    logic           ACK_I = 1'b0;
    logic [15:0]    DAT_I = '0;
    logic [6:0]     LB_ADR_O;
    logic [15:0]    LB_DAT_O;
    logic           LB_WE_O, DISP_BANK_O, UNDERRUN_O;

    always #5 clk = ~clk;

    mgia_line_fetch #(.WORDS_PER_LINE(WPL), .AW(AW)) dut (
        .CLK_I_25MHZ (clk),
        .RST_I_N     (RST_I_N),
        .EN_I        (EN_I),
        .BASE_ADR_I  (BASE_ADR_I),
        .VSTART_I    (VSTART_I),
        .HSTART_I    (HSTART_I),
        .ADR_O       (ADR_O),
        .CYC_O       (CYC_O),
        .STB_O       (STB_O),
        .ACK_I       (ACK_I),
        .DAT_I       (DAT_I),
        .LB_ADR_O    (LB_ADR_O),
        .LB_DAT_O    (LB_DAT_O),
        .LB_WE_O     (LB_WE_O),
        .DISP_BANK_O (DISP_BANK_O),
        .UNDERRUN_O  (UNDERRUN_O)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // video RAM contents as a function of word address
    function automatic logic [15:0] fdat(input logic [22:0] a);
        return a[15:0] ^ {a[22:16], a[22:14]} ^ 16'h5A3C;
    endfunction

    // Reference model: frame/line bookkeeping, queue of expected LB writes
    logic [22:0] m_line = '0;
    bit          m_bank = 1'b0;
    bit          m_par  = 1'b0;
    logic [22:0] exp_q[$];

    task automatic model_evt(input bit v, input bit h, input bit en,
                             input logic [22:0] base, input int nw);
        bit act;
        bit wb;
        logic [22:0] a;
        act = 1'b0;
        wb  = 1'b0;
        if (v) begin
            m_line = base; m_bank = 1'b1; m_par = 1'b0; act = 1'b1; wb = 1'b0;
        end else if (h) begin
`ifdef MGIA_LINE_DOUBLE_EN
            act = m_par; m_par = ~m_par;
`else
            act = 1'b1;
`endif
            if (act) begin
                m_bank = ~m_bank; m_line = m_line + 23'(WPL); wb = ~m_bank;
            end
        end
        if (act && en)
            for (int i = 0; i < nw; i++) begin
                a = m_line + 23'(i);
                exp_q.push_back({wb, 6'(i), fdat(a)});
            end
    endtask

    // Wishbone slave model
    bit slave_en  = 1'b1;
    bit slave_rnd = 1'b0;
    int lat       = 0;
    initial begin
        int w;
        w = 0;
        forever begin
            @(negedge clk);
            if (slave_en) begin
                if (CYC_O && STB_O && RST_I_N) begin
                    if (slave_rnd ? ($urandom_range(0, 2) == 0) : (w >= lat)) begin
                        ACK_I = 1'b1; DAT_I = fdat(ADR_O); w = 0;
                    end else begin
                        ACK_I = 1'b0; w++;
                    end
                end else begin
                    ACK_I = 1'b0; w = 0;
                end
            end
        end
    end

    // Monitor, sampled just after each rising edge
    int ur_cnt = 0, we_err = 0, stab_err = 0, fetch_cnt = 0;
    initial begin
        bit cp, sp, taken;
        logic [22:0] ap, e;
        cp = 0; sp = 0; ap = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!RST_I_N) begin
                cp = 0; sp = 0;
            end else begin
                taken = ACK_I && cp && sp;
                if (LB_WE_O !== taken) we_err++;
                if (cp && sp && !taken && CYC_O && STB_O && ADR_O !== ap) stab_err++;
                if (CYC_O && !cp) fetch_cnt++;
                if (UNDERRUN_O) ur_cnt++;
                if (LB_WE_O) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL lb_write: unexpected write adr 0x%0h dat 0x%0h", LB_ADR_O, LB_DAT_O);
                    end else begin
                        e = exp_q.pop_front();
                        if ({LB_ADR_O, LB_DAT_O} !== e) begin
                            bad++;
                            $display("FAIL lb_write: got adr 0x%0h dat 0x%0h expected adr 0x%0h dat 0x%0h",
                                     LB_ADR_O, LB_DAT_O, e[22:16], e[15:0]);
                        end
                    end
                end
                cp = CYC_O; sp = STB_O; ap = ADR_O;
            end
        end
    end

    task automatic evt(input bit v, input bit h, input bit en,
                       input logic [22:0] base, input int nw);
        @(negedge clk);
        VSTART_I = v; HSTART_I = h; EN_I = en; BASE_ADR_I = base;
        model_evt(v, h, en, base, nw);
        @(negedge clk);
        VSTART_I = 1'b0; HSTART_I = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (CYC_O && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (CYC_O) begin
            bad++;
            $display("FAIL %s: fetch still active after %0d cycles, CYC_O=%0b expected 0", name, budget, CYC_O);
        end
    endtask

    task automatic ack_n(input int n);
        repeat (n) begin
            @(negedge clk);
            ACK_I = 1'b1; DAT_I = fdat(ADR_O);
        end
    endtask

    typedef struct {
        bit          v, h, en;
        logic [22:0] base;
        bit          bank;
        bit          cyc;
        logic [22:0] adr0;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int u0, f0;
        bit exp_bank[4];
        tbl[0] = '{1'b1, 1'b0, 1'b1, 23'h001000, 1'b1, 1'b1, 23'h001000};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 23'h000000, 1'b0, 1'b1, 23'h001028};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 23'h000000, 1'b1, 1'b1, 23'h001050};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 23'h000000, 1'b0, 1'b0, 23'h000000};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 23'h000000, 1'b1, 1'b1, 23'h0010A0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 23'h7FFFE0, 1'b1, 1'b1, 23'h7FFFE0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 23'h000000, 1'b0, 1'b1, 23'h000008};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 23'h002000, 1'b1, 1'b0, 23'h000000};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 23'h000000, 1'b0, 1'b1, 23'h002028};

        repeat (3) @(negedge clk);
        chk("rst_adr", ADR_O, 0);
        chk("rst_cyc", CYC_O, 0);
        chk("rst_stb", STB_O, 0);
        chk("rst_lb_we", LB_WE_O, 0);
        chk("rst_lb_adr", LB_ADR_O, 0);
        chk("rst_lb_dat", LB_DAT_O, 0);
        chk("rst_bank", DISP_BANK_O, 0);
        chk("rst_underrun", UNDERRUN_O, 0);
        RST_I_N = 1'b1;

`ifndef MGIA_LINE_DOUBLE_EN
        for (int i = 0; i < 9; i++) begin
            evt(tbl[i].v, tbl[i].h, tbl[i].en, tbl[i].base, WPL);
            chk($sformatf("vec%0d_bank", i), DISP_BANK_O, tbl[i].bank);
            chk($sformatf("vec%0d_cyc", i), CYC_O, tbl[i].cyc);
            if (tbl[i].cyc) chk($sformatf("vec%0d_adr0", i), ADR_O, tbl[i].adr0);
            wait_idle(120, $sformatf("vec%0d_done", i));
        end
        chk("vec_no_underrun", ur_cnt, 0);

        // ACK held off 3 cycles per word
        lat = 3;
        evt(0, 1, 1, 0, WPL);
        chk("stall_bank", DISP_BANK_O, 1);
        chk("stall_adr0", ADR_O, 23'h002050);
        wait_idle(250, "stall_done");
        chk("stall_stable", stab_err, 0);
        chk("stall_we_timing", we_err, 0);
        lat = 0;

        // line start after 10 words: abort, underrun, stale ACK ignored
        slave_en = 1'b0;
        ACK_I = 1'b0;
        u0 = ur_cnt;
        evt(0, 1, 1, 0, 10);
        ack_n(10);
        @(negedge clk);
        ACK_I = 1'b0; HSTART_I = 1'b1;
        model_evt(0, 1, 1, 0, WPL);
        @(negedge clk);
        HSTART_I = 1'b0; ACK_I = 1'b1; DAT_I = 16'hDEAD;
        chk("abort_cyc_drop", CYC_O, 0);
        chk("abort_bank", DISP_BANK_O, 1);
        @(negedge clk);
        ACK_I = 1'b0;
        chk("abort_restart_cyc", CYC_O, 1);
        chk("abort_restart_adr", ADR_O, 23'h0020A0);
        chk("abort_underrun_once", ur_cnt - u0, 1);
        slave_en = 1'b1;
        wait_idle(120, "abort_done");

        // line start coincident with the final ACK
        slave_en = 1'b0;
        u0 = ur_cnt;
        evt(0, 1, 1, 0, WPL);
        ack_n(WPL - 1);
        @(negedge clk);
        ACK_I = 1'b1; DAT_I = fdat(ADR_O); HSTART_I = 1'b1;
        model_evt(0, 1, 1, 0, WPL);
        @(negedge clk);
        ACK_I = 1'b0; HSTART_I = 1'b0;
        chk("coin_cyc", CYC_O, 1);
        chk("coin_adr", ADR_O, 23'h0020F0);
        chk("coin_bank", DISP_BANK_O, 1);
        ack_n(WPL);
        @(negedge clk);
        ACK_I = 1'b0;
        chk("end_cyc_low", CYC_O, 0);
        chk("coin_no_underrun", ur_cnt - u0, 0);
        slave_en = 1'b1;
`else
        // line doubling: four HSTARTs give two fetches
        evt(1, 0, 1, 23'h001000, WPL);
        wait_idle(120, "dbl_v_done");
        f0 = fetch_cnt;
        exp_bank[0] = 1'b1; exp_bank[1] = 1'b0; exp_bank[2] = 1'b0; exp_bank[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            evt(0, 1, 1, 0, WPL);
            chk($sformatf("dbl_bank%0d", k), DISP_BANK_O, exp_bank[k]);
            wait_idle(120, $sformatf("dbl_done%0d", k));
        end
        chk("dbl_fetches", fetch_cnt - f0, 2);
        chk("dbl_line", m_line, 23'h001050);
`endif

        // randomized frames and lines with random ACK spacing
        slave_rnd = 1'b1;
        repeat (25) begin
            bit v, h, en;
            logic [22:0] b;
            v  = ($urandom_range(0, 7) == 0);
            h  = v ? bit'($urandom_range(0, 1)) : 1'b1;
            en = ($urandom_range(0, 3) != 0);
            b  = 23'($urandom);
            evt(v, h, en, b, WPL);
            chk("rnd_bank", DISP_BANK_O, m_bank);
            wait_idle(400, "rnd_done");
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        slave_rnd = 1'b0;

        @(negedge clk);
        chk("all_writes_seen", exp_q.size(), 0);
        chk("we_timing", we_err, 0);
        chk("stb_adr_stable", stab_err, 0);
`ifndef MGIA_LINE_DOUBLE_EN
        chk("underrun_total", ur_cnt, 1);
`else
        chk("underrun_total", ur_cnt, 0);
`endif

        // reset asserted mid-fetch drops the bus asynchronously
        evt(1, 0, 1, 23'h003000, WPL);
        repeat (5) @(negedge clk);
        #2 RST_I_N = 1'b0;
        #1;
        chk("arst_cyc", CYC_O, 0);
        chk("arst_stb", STB_O, 0);
        chk("arst_lb_we", LB_WE_O, 0);
        exp_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mgia_line_fetch.md
Name: mgia_line_fetch

Overview:
- Line-prefetch scheduler for the MGIA monochrome video path.
- While the pixel shifter displays line N from one half of a ping-pong line buffer, this block fetches line N+1 from video RAM into the other half.
- Fetches use a classic Wishbone B3 master, one outstanding transfer at a time.
- Sits between the CRTC timing generator (HSTART/VSTART pulses), the system bus and the 128x16 dual-port line buffer. The shifter reads the buffer at {DISP_BANK_O, 6-bit word address}.

Parameters:
- WORDS_PER_LINE, 40, 16-bit words fetched per line (640 px / 16); legal 1..64.
- AW, 23, Wishbone word-address width.

Ports:
- CLK_I_25MHZ  in  1  pixel/system clock.
- RST_I_N  in  1  asynchronous, active-low reset.
- EN_I  in  1  fetch enable; low suppresses new fetches.
- BASE_ADR_I  in  AW  frame base word address; sampled on VSTART_I.
- VSTART_I  in  1  1-cycle pulse at frame start (inside vblank).
- HSTART_I  in  1  1-cycle pulse at start of each displayed line.
- ADR_O  out  AW  Wishbone word address.
- CYC_O  out  1  Wishbone cycle.
- STB_O  out  1  Wishbone strobe.
- ACK_I  in  1  Wishbone acknowledge.
- DAT_I  in  16  Wishbone read data.
- LB_ADR_O  out  7  line-buffer write address {write bank, word index}.
- LB_DAT_O  out  16  line-buffer write data.
- LB_WE_O  out  1  line-buffer write enable.
- DISP_BANK_O  out  1  bank the shifter reads.
- UNDERRUN_O  out  1  1-cycle pulse when a fetch was still incomplete at HSTART.

Behaviour:
- Reset values: all outputs 0. Internal state: FSM IDLE, line address 0, word counter 0.
- Write bank is always ~DISP_BANK_O.
- FSM states: IDLE, FETCH.
- IDLE to FETCH on a start event, only if EN_I=1.
  - VSTART_I: line_adr <= BASE_ADR_I, DISP_BANK_O <= 1, fetch into bank 0.
  - HSTART_I: DISP_BANK_O toggles, line_adr <= line_adr + WORDS_PER_LINE, fetch into the new write bank.
  - Both events happen even when EN_I=0; only the fetch is suppressed.
- FETCH:
  - CYC_O=STB_O=1 from the cycle after the start event.
  - ADR_O = line_adr + word index.
  - On each ACK_I: index increments and ADR_O advances next cycle, with STB_O held.
  - On the ACK of index WORDS_PER_LINE-1: CYC_O/STB_O drop next cycle and the FSM returns to IDLE.
  - Without ACK, STB_O and ADR_O hold indefinitely.
- Line-buffer write:
  - Registered; one cycle after each ACK.
  - LB_WE_O=1, LB_DAT_O = captured DAT_I, LB_ADR_O = {write bank at fetch start, index}.
  - Bank is latched at fetch start, so a later toggle does not redirect in-flight writes.
- Start event while in FETCH:
  - Current fetch is aborted: CYC_O/STB_O drop that clock edge, and any later ACK is ignored.
  - UNDERRUN_O pulses for 1 cycle.
  - The new fetch starts as above.
  - Exception: if the start event coincides with the ACK of the final word, the fetch counts as complete, its write still occurs, and there is no underrun.
- VSTART_I and HSTART_I in the same cycle: VSTART_I wins and HSTART_I is ignored.
- EN_I falling during FETCH: the current line completes; no further fetches start.
- Address arithmetic is modulo 2^AW and wraps silently.
- Reset asserted mid-fetch: CYC_O/STB_O/LB_WE_O drop asynchronously.

Optional Feature:
- Macro: MGIA_LINE_DOUBLE_EN.
- Defined:
  - A line-parity bit, cleared on VSTART_I, toggles on every HSTART_I.
  - Only HSTART_I with parity=1 before the toggle flips the bank, advances line_adr and starts a fetch.
  - Each fetched line is therefore shown twice (240-line mode).
  - Underrun is checked only on acting HSTARTs.
- Undefined: every HSTART_I acts; the parity logic is absent.

Decomposition:
- Package mgia_pkg holds:
  - FSM state enum.
  - LB_AW=7 and WORD_W=16 constants.
  - Default WORDS_PER_LINE=40.
- One natural sub-module: mgia_wb_burst_rd, a Wishbone sequential-read engine taking start/abort/base/count and emitting a data-valid/index stream.
- The parent owns banking, line addressing and underrun detection.

Test Plan:
- Reset, then VSTART with BASE=0x1000 and single-cycle-latency ACK:
  - ADR_O runs 0x1000..0x1027.
  - 40 LB writes to addresses 0x00..0x27, DISP_BANK_O=1.
  - CYC_O low 1 cycle after the 40th ACK.
- Following HSTART:
  - DISP_BANK_O=0.
  - ADR_O starts at 0x1028.
  - LB_ADR_O runs 0x40..0x67.
  - UNDERRUN_O stays 0.
- ACK held off 3 cycles per word:
  - STB_O and ADR_O stable throughout.
  - No LB_WE_O until the cycle after each ACK.
- HSTART after 10 words:
  - UNDERRUN_O pulses once, CYC_O drops, the stale ACK is ignored.
  - New fetch from line_adr+40 into the toggled bank, index 0.
- HSTART coincident with the final ACK: write at index 39 occurs, no underrun. VSTART+HSTART together: address reloads to BASE, DISP_BANK_O=1.
- With MGIA_LINE_DOUBLE_EN and 4 HSTARTs after VSTART: exactly 2 fetches (line addresses BASE+40, BASE+80), and the bank toggles twice.
